secret_return_check: RTL and testbench

//   Return-side companion to the jump filter: tracks call/return pairs on the committed

---
 rtl/secret_return_check.sv | 102 ++++++++++
 tb/tb_secret_return_check.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/secret_return_check.sv
// Shadow-stack return checker: pushes JAL/JALR link addresses, pops on JR $ra and nulls mismatching returns.
// Latency 1 cycle; single output register, in_ready = !out_valid | out_ready, word held while stalled.
module secret_return_check #(
    parameter int DEPTH  = 8,
    parameter bit STRICT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_instr,
    output logic        violation,
    output logic [31:0] viol_pc,
    output logic [7:0]  overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   stk [DEPTH];
    logic [AW-1:0] sp;
    logic [AW:0]   cnt;

    logic          accept;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic [4:0]    rs;
    logic          is_call;
    logic          is_ret;
    logic [AW-1:0] sp_dec;
    logic [31:0]   top;
    logic          ret_bad;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign op      = in_instr[31:26];
    assign fn      = in_instr[5:0];
    assign rs      = in_instr[25:21];
    assign is_call = (op == 6'd3) || (op == 6'd0 && fn == 6'd9);
    assign is_ret  = (op == 6'd0) && (fn == 6'd8) && (rs == 5'd31);

    // sp points at the next free slot; when full that slot is also the oldest entry.
    assign sp_dec  = sp - 1'b1;
    assign top     = stk[sp_dec];
    assign ret_bad = is_ret && ((cnt != '0) ? (top != in_target) : STRICT);

    always_ff @(posedge clk) begin
        if (accept && is_call) begin
            stk[sp] <= in_pc + 32'd8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp           <= '0;
            cnt          <= '0;
            overflow_cnt <= '0;
        end else if (accept) begin
            if (is_call) begin
                sp <= sp + 1'b1;
                if (cnt == FULL) begin
                    if (overflow_cnt != 8'hff) begin
                        overflow_cnt <= overflow_cnt + 8'd1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (is_ret && cnt != '0) begin
                sp  <= sp_dec;
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            violation <= 1'b0;
            viol_pc   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= ret_bad ? 64'd0 : in_instr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Only the first bad return is recorded.
            if (accept && ret_bad && !violation) begin
                violation <= 1'b1;
                viol_pc   <= in_pc;
            end
        end
    end

endmodule

// File: tb/tb_secret_return_check.sv
// Directed bench for secret_return_check; a STRICT=0 instance shares the stimulus of the default one.
module tb_secret_return_check;

    localparam logic [31:0] JAL  = 32'h0C000040;
    localparam logic [31:0] JALR = 32'h0040F809;
    localparam logic [31:0] JR   = 32'h03E00008;
    localparam logic [31:0] ADD  = 32'h00851020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_target = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, violation;
    logic [63:0] out_instr;
    logic [31:0] viol_pc;
    logic [7:0]  overflow_cnt;

    logic        in_ready0, out_valid0, violation0;
    logic [63:0] out_instr0;
    logic [31:0] viol_pc0;
    logic [7:0]  overflow_cnt0;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    secret_return_check #(.DEPTH(8), .STRICT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .violation(violation), .viol_pc(viol_pc), .overflow_cnt(overflow_cnt)
    );

    secret_return_check #(.DEPTH(8), .STRICT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc), .in_target(in_target),
        .out_valid(out_valid0), .out_ready(out_ready), .out_instr(out_instr0),
        .violation(violation0), .viol_pc(viol_pc0), .overflow_cnt(overflow_cnt0)
    );

    // Starts and ends on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one word for a single accepted cycle; ends on the falling edge after acceptance.
    task automatic send(input logic [63:0] instr, input logic [31:0] pc, input logic [31:0] tgt);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            ntotal++;
            $display("FAIL send_wait: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        in_instr  = instr;
        in_pc     = pc;
        in_target = tgt;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ntotal++;
        if ({out_valid, out_instr, violation, viol_pc, overflow_cnt, in_ready} !== {1'b0, 64'd0, 1'b0, 32'd0, 8'd0, 1'b1}) begin
            $display("FAIL reset_state: ov=%0b oi=%h v=%0b vpc=%h ovf=%0d ir=%0b required 0/0/0/0/0/1",
                     out_valid, out_instr, violation, viol_pc, overflow_cnt, in_ready);
        end else npass++;
    endtask

    task automatic test_match();
        do_reset();
        send({32'hABCD0001, JAL}, 32'h400, 32'h0);
        ntotal++;
        if (out_valid !== 1'b1 || out_instr !== {32'hABCD0001, JAL}) begin
            $display("FAIL match_jal_fwd: ov=%0b oi=%h required 1/%h", out_valid, out_instr, {32'hABCD0001, JAL});
        end else npass++;
        send({32'h0, JR}, 32'h440, 32'h408);
        ntotal++;
        if (out_valid !== 1'b1 || out_instr !== {32'h0, JR}) begin
            $display("FAIL match_ret_fwd: ov=%0b oi=%h required 1/%h", out_valid, out_instr, {32'h0, JR});
        end else npass++;
        ntotal++;
        if (violation !== 1'b0) begin
            $display("FAIL match_no_viol: violation=%0b required 0", violation);
        end else npass++;
    endtask

    task automatic test_mismatch();
        do_reset();
        send({32'h0, JAL}, 32'h400, 32'h0);
        send({32'h5555AAAA, JR}, 32'h404, 32'h40C);
        ntotal++;
        if (out_valid !== 1'b1 || out_instr !== 64'd0) begin
            $display("FAIL mismatch_null: ov=%0b oi=%h required 1/0", out_valid, out_instr);
        end else npass++;
        ntotal++;
        if (violation !== 1'b1 || viol_pc !== 32'h404) begin
            $display("FAIL mismatch_latch: v=%0b vpc=%h required 1/00000404", violation, viol_pc);
        end else npass++;
        // A second bad return must not move viol_pc.
        send({32'h0, JR}, 32'h480, 32'h999);
        ntotal++;
        if (viol_pc !== 32'h404 || out_instr !== 64'd0) begin
            $display("FAIL mismatch_sticky: vpc=%h oi=%h required 00000404/0", viol_pc, out_instr);
        end else npass++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send({32'h0, JAL}, 32'h2000 + 32'(i) * 32'h10, 32'h0);
        end
        ntotal++;
        if (overflow_cnt !== 8'd1 || overflow_cnt0 !== 8'd1) begin
            $display("FAIL ovf_count: strict=%0d lax=%0d required 1/1", overflow_cnt, overflow_cnt0);
        end else npass++;
        for (int i = 8; i >= 1; i--) begin
            send({32'h0, JR}, 32'h3000, 32'h2008 + 32'(i) * 32'h10);
            ntotal++;
            if (out_instr !== {32'h0, JR} || violation !== 1'b0) begin
                $display("FAIL ovf_ret_%0d: oi=%h v=%0b required %h/0", i, out_instr, violation, {32'h0, JR});
            end else npass++;
        end
        send({32'h0, JR}, 32'h3004, 32'h2008);
        ntotal++;
        if (out_instr !== 64'd0 || violation !== 1'b1 || viol_pc !== 32'h3004) begin
            $display("FAIL ovf_empty_strict: oi=%h v=%0b vpc=%h required 0/1/00003004", out_instr, violation, viol_pc);
        end else npass++;
        ntotal++;
        if (out_instr0 !== {32'h0, JR} || violation0 !== 1'b0) begin
            $display("FAIL ovf_empty_lax: oi=%h v=%0b required %h/0", out_instr0, violation0, {32'h0, JR});
        end else npass++;
    endtask

    task automatic test_jalr();
        do_reset();
        send({32'h0, JALR}, 32'h1000, 32'h0);
        send({32'h0, JR}, 32'h1100, 32'h1008);
        ntotal++;
        if (out_instr !== {32'h0, JR} || violation !== 1'b0) begin
            $display("FAIL jalr_ret: oi=%h v=%0b required %h/0", out_instr, violation, {32'h0, JR});
        end else npass++;
        // Stack must be empty again, so a further return is flagged.
        send({32'h0, JR}, 32'h1104, 32'h1008);
        ntotal++;
        if (violation !== 1'b1 || out_instr !== 64'd0) begin
            $display("FAIL jalr_empty: v=%0b oi=%h required 1/0", violation, out_instr);
        end else npass++;
    endtask

    task automatic test_back_to_back();
        int bad_hold = 0;
        do_reset();
        out_ready = 1'b0;
        send({32'h0, JAL}, 32'h500, 32'h0);
        in_instr  = {32'h0, ADD};
        in_pc     = 32'h504;
        in_target = 32'h0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== {32'h0, JAL}) bad_hold++;
            @(posedge clk);
            @(negedge clk);
        end
        ntotal++;
        if (bad_hold != 0) begin
            $display("FAIL stall_hold: %0d stalled cycles wrong, required 0", bad_hold);
        end else npass++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ntotal++;
        if (out_valid !== 1'b1 || out_instr !== {32'h0, ADD}) begin
            $display("FAIL stall_second: ov=%0b oi=%h required 1/%h", out_valid, out_instr, {32'h0, ADD});
        end else npass++;
        in_instr  = {32'h0, JR};
        in_pc     = 32'h508;
        in_target = 32'h508;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ntotal++;
        if (out_valid !== 1'b1 || out_instr !== {32'h0, JR} || violation !== 1'b0) begin
            $display("FAIL stall_third: ov=%0b oi=%h v=%0b required 1/%h/0", out_valid, out_instr, violation, {32'h0, JR});
        end else npass++;
        @(posedge clk);
        @(negedge clk);
        ntotal++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stall_no_dup: ov=%0b required 0", out_valid);
        end else npass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        send({32'h0, JAL}, 32'h600, 32'h0);
        send({32'h0, JAL}, 32'h610, 32'h0);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ntotal++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL rst_pre_stall: ov=%0b ir=%0b required 1/0", out_valid, in_ready);
        end else npass++;
        #2 rst = 1'b1;
        #1;
        ntotal++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 64'd0) begin
            $display("FAIL rst_async: ov=%0b ir=%0b oi=%h required 0/1/0", out_valid, in_ready, out_instr);
        end else npass++;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send({32'h0, JR}, 32'h700, 32'h618);
        ntotal++;
        if (violation !== 1'b1 || viol_pc !== 32'h700 || out_instr !== 64'd0) begin
            $display("FAIL rst_empty_strict: v=%0b vpc=%h oi=%h required 1/00000700/0", violation, viol_pc, out_instr);
        end else npass++;
        ntotal++;
        if (violation0 !== 1'b0 || out_instr0 !== {32'h0, JR}) begin
            $display("FAIL rst_empty_lax: v=%0b oi=%h required 0/%h", violation0, out_instr0, {32'h0, JR});
        end else npass++;
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_overflow();
        test_jalr();
        test_back_to_back();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
